// File: rtl/readout_pkg.sv
// -----------------------------------------------------------------------------
// readout_pkg
// Shared types and constants for the sample_readout block: FSM state encoding,
// header framing constants, the per-sample word layout and a channel-select
// helper used by the serialiser.
// -----------------------------------------------------------------------------
package readout_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = NUM_CH * BYTE_W;

    localparam logic [BYTE_W-1:0] HDR_SYNC = 8'hA5;
    localparam int unsigned       HDR_LEN  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        HDR   = 3'd2,
        READ  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // One sample across all channels; index 0 is ch1 (ram_q1), index 3 is ch4.
    typedef logic [NUM_CH-1:0][BYTE_W-1:0] sample_t;

    // Index of the lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [1:0] first_ch(input logic [NUM_CH-1:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// -----------------------------------------------------------------------------
// readout_fifo
// Synchronous prefetch FIFO between the capture-RAM read port and the byte
// serialiser. Show-ahead read: o_data_c always presents the head entry.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_flush      synchronous flush, wins over push/pop
//   i_push       write i_data (ignored when full)
//   i_data       entry to write
//   i_pop        drop the head entry (ignored when empty)
//   o_data_c     head entry (combinational view of storage)
//   o_count      number of stored entries
// -----------------------------------------------------------------------------
module readout_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data_c,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointer increment that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push   = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop    = i_pop && (r_count != '0);
    assign o_data_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sample_readout.sv
// -----------------------------------------------------------------------------
// sample_readout
// Reads a triggered record out of the four capture RAMs in time order,
// starting triggerpoint samples before the trigger address, and serialises the
// enabled channels (ch1..ch4) into a valid/ready byte stream.
// Optional feature macro: READOUT_HEADER_EN -- when defined, a 4-byte header
// (A5, {0,ch_en}, nsmp high bits, nsmp low byte) precedes the sample bytes.
//   clk, rst_n                 clock, asynchronous active-low reset
//   readout_req                1-cycle start request (accepted in IDLE only)
//   abort                      cancel readout, flush pipeline, no done pulse
//   data_ready                 record complete; gates leaving ARM
//   wraddress_triggerpoint     RAM address of the trigger
//   triggerpoint               number of pre-trigger samples
//   nsmp                       samples to send (0 = none)
//   ch_en                      channel enable mask, bit0 = ch1
//   rden, rdaddress            shared capture-RAM read port
//   ram_q1..ram_q4             RAM data, valid RAM_LAT cycles after rden
//   tx_data, tx_valid          output byte stream
//   tx_ready                   sink handshake
//   busy                       readout in progress
//   done                       1-cycle pulse after the last byte
// -----------------------------------------------------------------------------
module sample_readout
    import readout_pkg::*;
#(
    parameter int unsigned RAM_WIDTH  = 10,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 readout_req,
    input  logic                 abort,
    input  logic                 data_ready,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [NUM_CH-1:0]    ch_en,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [BYTE_W-1:0]    ram_q1,
    input  logic [BYTE_W-1:0]    ram_q2,
    input  logic [BYTE_W-1:0]    ram_q3,
    input  logic [BYTE_W-1:0]    ram_q4,
    output logic [BYTE_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    state_t                r_state;
    logic [NUM_CH-1:0]     r_ch_en;
    logic [RAM_WIDTH-1:0]  r_nsmp;
    logic [RAM_WIDTH-1:0]  r_triggerpoint;
    logic [RAM_WIDTH-1:0]  r_next_addr;
    logic [RAM_WIDTH-1:0]  r_remaining;
    logic                  r_rden;
    logic [RAM_WIDTH-1:0]  r_rdaddress;
    logic [RAM_LAT-1:0]    r_vld;
    logic [CNT_W-1:0]      r_inflight;
    sample_t               r_word;
    logic [NUM_CH-1:0]     r_mask;
    logic [BYTE_W-1:0]     r_tx_data;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_done;
`ifdef READOUT_HEADER_EN
    logic [1:0]            r_hdr_idx;
    logic [BYTE_W-1:0]     w_hdr_byte;
`endif

    sample_t               w_ram_word;
    logic [WORD_W-1:0]     w_head_bits;
    sample_t               w_head;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_can_load;
    logic                  w_drained;
    logic [1:0]            w_load_ch;
    logic [1:0]            w_pop_ch;

    assign w_ram_word = {ram_q4, ram_q3, ram_q2, ram_q1};
    assign w_head     = sample_t'(w_head_bits);
    assign w_push     = r_vld[RAM_LAT-1];
    assign w_load_ch  = first_ch(r_mask);
    assign w_pop_ch   = first_ch(r_ch_en);

    // Output register is free for a new byte this cycle.
    assign w_can_load = !r_tx_valid || tx_ready;

    // Credit check: a read is issued only if its data is guaranteed a FIFO slot.
    assign w_issue = (r_state == READ) && (r_remaining != '0) &&
                     ((SUM_W'(w_fifo_count) + SUM_W'(r_inflight)) < SUM_W'(FIFO_DEPTH));

    // Next sample word is fetched only once the previous one is fully emitted.
    assign w_pop = w_can_load && (r_mask == '0) && (w_fifo_count != '0) && !abort &&
                   ((r_state == READ) || (r_state == DRAIN));

    // Nothing pending anywhere and the final byte (if any) completes this cycle.
    assign w_drained = (r_inflight == '0) && (w_fifo_count == '0) && (r_mask == '0) &&
                       (!r_tx_valid || tx_ready);

`ifdef READOUT_HEADER_EN
    // Header byte selected by position.
    always_comb begin
        w_hdr_byte = HDR_SYNC;
        case (r_hdr_idx)
            2'd1:    w_hdr_byte = {4'h0, r_ch_en};
            2'd2:    w_hdr_byte = 8'(r_nsmp >> 8);
            2'd3:    w_hdr_byte = 8'(r_nsmp);
            default: w_hdr_byte = HDR_SYNC;
        endcase
    end
`endif

    readout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (abort),
        .i_push   (w_push),
        .i_data   (w_ram_word),
        .i_pop    (w_pop),
        .o_data_c (w_head_bits),
        .o_count  (w_fifo_count)
    );

    // FSM, read engine and serialiser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_ch_en        <= '0;
            r_nsmp         <= '0;
            r_triggerpoint <= '0;
            r_next_addr    <= '0;
            r_remaining    <= '0;
            r_rden         <= 1'b0;
            r_rdaddress    <= '0;
            r_vld          <= '0;
            r_inflight     <= '0;
            r_word         <= '0;
            r_mask         <= '0;
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
`ifdef READOUT_HEADER_EN
            r_hdr_idx      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Cancel: drop in-flight reads and any partially sent sample.
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_rden      <= 1'b0;
                r_vld       <= '0;
                r_inflight  <= '0;
                r_mask      <= '0;
                r_remaining <= '0;
                r_tx_valid  <= 1'b0;
`ifdef READOUT_HEADER_EN
                r_hdr_idx   <= '0;
`endif
            end else begin
                // RAM read port and latency tracking.
                r_rden <= w_issue;
                if (w_issue) begin
                    r_rdaddress <= r_next_addr;
                    r_next_addr <= r_next_addr + RAM_WIDTH'(1);
                    r_remaining <= r_remaining - RAM_WIDTH'(1);
                end
                r_vld[0] <= r_rden;
                for (int i = 1; i < int'(RAM_LAT); i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
                r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);

                // Serialiser: header bytes, remaining channels of current word, or a new word.
                if (w_can_load) begin
                    r_tx_valid <= 1'b0;
`ifdef READOUT_HEADER_EN
                    if (r_state == HDR) begin
                        r_tx_data  <= w_hdr_byte;
                        r_tx_valid <= 1'b1;
                    end else
`endif
                    if (r_mask != '0) begin
                        r_tx_data  <= r_word[w_load_ch];
                        r_tx_valid <= 1'b1;
                        r_mask     <= r_mask & ~(NUM_CH'(1) << w_load_ch);
                    end else if (w_pop) begin
                        r_word     <= w_head;
                        r_tx_data  <= w_head[w_pop_ch];
                        r_tx_valid <= 1'b1;
                        r_mask     <= r_ch_en & ~(NUM_CH'(1) << w_pop_ch);
                    end
                end

                case (r_state)
                    IDLE: begin
                        if (readout_req) begin
                            r_state        <= ARM;
                            r_busy         <= 1'b1;
                            r_ch_en        <= ch_en;
                            r_nsmp         <= nsmp;
                            r_triggerpoint <= triggerpoint;
                        end
                    end
                    ARM: begin
                        if (data_ready) begin
                            // Subtraction wraps modulo the RAM size.
                            r_next_addr <= wraddress_triggerpoint - r_triggerpoint;
                            r_remaining <= (r_ch_en == '0) ? '0 : r_nsmp;
`ifdef READOUT_HEADER_EN
                            r_state     <= HDR;
                            r_hdr_idx   <= '0;
`else
                            r_state     <= READ;
`endif
                        end
                    end
`ifdef READOUT_HEADER_EN
                    HDR: begin
                        if (w_can_load) begin
                            r_hdr_idx <= r_hdr_idx + 2'd1;
                            if (r_hdr_idx == 2'(HDR_LEN - 1)) r_state <= READ;
                        end
                    end
`endif
                    READ: begin
                        if (r_remaining == '0) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        if (w_drained) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rden      = r_rden;
    assign rdaddress = r_rdaddress;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sample_readout.sv
// -----------------------------------------------------------------------------
// tb_sample_readout
// Self-checking bench for sample_readout: behavioural capture-RAM model with
// configurable latency, a sink with selectable tx_ready patterns, and a
// reference model that derives the expected address and byte streams directly
// from the record parameters.
// -----------------------------------------------------------------------------
module tb_sample_readout;

    localparam int unsigned RW    = 10;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;
    localparam int          NREC  = 1 << RW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          readout_req = 1'b0;
    logic          abort = 1'b0;
    logic          data_ready = 1'b1;
    logic [RW-1:0] wraddress_triggerpoint = '0;
    logic [RW-1:0] triggerpoint = '0;
    logic [RW-1:0] nsmp = '0;
    logic [3:0]    ch_en = '0;
    logic          rden;
    logic [RW-1:0] rdaddress;
    logic [7:0]    ram_q1, ram_q2, ram_q3, ram_q4;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;

    logic [7:0]    mem [4][NREC];
    logic [31:0]   pipe [LAT];

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    got_bytes[$];
    int            got_addr[$];
    logic [7:0]    exp_bytes[$];
    int            exp_addr[$];
    int            done_cnt = 0;
    int            stall_err = 0;
    bit            stall_chk_en = 1'b0;
    int            ready_mode = 0;
    int            cyc = 0;
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [7:0]    prev_d = '0;

    sample_readout #(
        .RAM_WIDTH  (RW),
        .RAM_LAT    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .readout_req            (readout_req),
        .abort                  (abort),
        .data_ready             (data_ready),
        .wraddress_triggerpoint (wraddress_triggerpoint),
        .triggerpoint           (triggerpoint),
        .nsmp                   (nsmp),
        .ch_en                  (ch_en),
        .rden                   (rden),
        .rdaddress              (rdaddress),
        .ram_q1                 (ram_q1),
        .ram_q2                 (ram_q2),
        .ram_q3                 (ram_q3),
        .ram_q4                 (ram_q4),
        .tx_data                (tx_data),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clk = ~clk;

    // Capture RAMs: data appears LAT cycles after rden; junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= rden ? {mem[3][rdaddress], mem[2][rdaddress], mem[1][rdaddress], mem[0][rdaddress]}
                        : $urandom;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign {ram_q4, ram_q3, ram_q2, ram_q1} = pipe[LAT-1];

    // Sink ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream, read-port and stall-stability monitor.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_bytes.push_back(tx_data);
        if (rden) got_addr.push_back(int'(rdaddress));
        if (done) done_cnt++;
        if (stall_chk_en && prev_v && !prev_r && (!tx_valid || tx_data != prev_d)) stall_err++;
        prev_v = tx_valid;
        prev_r = tx_ready;
        prev_d = tx_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: record read in time order from the pre-trigger start.
    function automatic void build_expect(input int t_tp, input int t_wtp, input int t_n,
                                         input logic [3:0] t_en);
        int start;
        int a;
        exp_bytes.delete();
        exp_addr.delete();
`ifdef READOUT_HEADER_EN
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back({4'h0, t_en});
        exp_bytes.push_back(8'(t_n / 256));
        exp_bytes.push_back(8'(t_n % 256));
`endif
        if (t_en == 4'h0) return;
        start = (t_wtp - t_tp + NREC) % NREC;
        for (int i = 0; i < t_n; i++) begin
            a = (start + i) % NREC;
            exp_addr.push_back(a);
            for (int c = 0; c < 4; c++) begin
                if (t_en[c]) exp_bytes.push_back(mem[c][a]);
            end
        end
    endfunction

    task automatic compare_streams(input string tag, input bit prefix_only);
        if (!prefix_only) begin
            check_eq({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
            check_eq({tag, "_naddr"}, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            check_eq($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
    endtask

    task automatic start_readout(input int t_tp, input int t_wtp, input int t_n,
                                 input logic [3:0] t_en, input int mode, input bit dr);
        build_expect(t_tp, t_wtp, t_n, t_en);
        ready_mode   = mode;
        got_bytes.delete();
        got_addr.delete();
        done_cnt     = 0;
        stall_err    = 0;
        stall_chk_en = 1'b1;
        triggerpoint           = RW'(t_tp);
        wraddress_triggerpoint = RW'(t_wtp);
        nsmp                   = RW'(t_n);
        ch_en                  = t_en;
        data_ready             = dr;
        readout_req = 1'b1;
        tick();
        readout_req = 1'b0;
    endtask

    task automatic run_readout(input string tag, input int t_tp, input int t_wtp, input int t_n,
                               input logic [3:0] t_en, input int mode, input int dr_wait);
        int cnt;
        start_readout(t_tp, t_wtp, t_n, t_en, mode, dr_wait == 0);
        check_eq({tag, "_busy_start"}, busy, 1);
        if (dr_wait > 0) begin
            repeat (dr_wait) tick();
            check_eq({tag, "_rden_while_waiting"}, got_addr.size(), 0);
            check_eq({tag, "_busy_waiting"}, busy, 1);
            data_ready = 1'b1;
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < 5000);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_after"}, busy, 0);
        compare_streams(tag, 1'b0);
        check_eq({tag, "_stall_stable"}, stall_err, 0);
    endtask

    initial begin
        int cnt;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < NREC; a++) mem[c][a] = 8'($urandom);

        // Reset values.
        #1;
        check_eq("rst_rden", rden, 0);
        check_eq("rst_rdaddress", rdaddress, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        #20 rst_n = 1'b1;
        repeat (3) tick();

        // Wrap past the top of the RAM, all channels, full-rate sink.
        run_readout("t1_wrap", 100, 50, 8, 4'b1111, 0, 0);
        // Sparse channel mask.
        run_readout("t2_ch0101", 10, 200, 3, 4'b0101, 0, 0);
        // Sink ready one cycle in three.
        run_readout("t3_stall", 5, 300, 12, 4'b1111, 1, 0);
        // Request before the record is complete.
        run_readout("t4_dready", 20, 700, 6, 4'b0011, 0, 20);

        // Abort part-way through a 32-byte readout.
        start_readout(100, 50, 8, 4'b1111, 0, 1'b1);
        cnt = 0;
        while (got_bytes.size() < 5 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("t5_bytes_before_abort", got_bytes.size() >= 5, 1);
        stall_chk_en = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_eq("t5_tx_valid_after_abort", tx_valid, 0);
        check_eq("t5_busy_after_abort", busy, 0);
        check_eq("t5_rden_after_abort", rden, 0);
        repeat (40) @(negedge clk);
        check_eq("t5_no_done", done_cnt, 0);
        check_eq("t5_partial", got_bytes.size() < exp_bytes.size(), 1);
        compare_streams("t5_prefix", 1'b1);
        run_readout("t5_full", 100, 50, 8, 4'b1111, 0, 0);

        // Empty record and empty channel mask.
        run_readout("t6_nsmp0", 0, 0, 0, 4'b1111, 0, 0);
        run_readout("t7_chen0", 3, 9, 5, 4'b0000, 0, 0);

        // abort wins over a simultaneous readout_req.
        got_addr.delete();
        @(posedge clk);
        #1;
        readout_req = 1'b1;
        abort       = 1'b1;
        tick();
        readout_req = 1'b0;
        abort       = 1'b0;
        check_eq("t8_busy_prio", busy, 0);
        repeat (10) tick();
        check_eq("t8_no_rden", got_addr.size(), 0);
        check_eq("t8_tx_valid", tx_valid, 0);

        // Asynchronous reset in the middle of a readout.
        start_readout(0, 512, 20, 4'b1111, 0, 1'b1);
        cnt = 0;
        while (got_bytes.size() < 6 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        stall_chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t9_rst_busy", busy, 0);
        check_eq("t9_rst_tx_valid", tx_valid, 0);
        check_eq("t9_rst_tx_data", tx_data, 0);
        check_eq("t9_rst_rden", rden, 0);
        check_eq("t9_rst_rdaddress", rdaddress, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        run_readout("t9_after_rst", 0, 512, 20, 4'b1111, 2, 0);

        // Randomised records, masks and sink behaviour.
        for (int k = 0; k < 8; k++) begin
            run_readout($sformatf("rnd%0d", k),
                        int'($urandom_range(0, NREC - 1)), int'($urandom_range(0, NREC - 1)),
                        int'($urandom_range(0, 40)), 4'($urandom_range(0, 15)),
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 1)) * 5);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
